slatch_wr_arb: RTL and testbench
================================

SLATCH_WR_ARB -- requirements
Module: slatch_wr_arb

Interface
REQ-001 Parameter NREG, 6: number of slatchc registers in the bank; legal range 1..8.
REQ-002 Parameter DW, 16: register data width.
REQ-003 sys_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 resl  in  1  synchronous active-low reset, sampled on sys_clk rising edge.
REQ-005 hold  in  1  when high, no new grant is issued; a transaction already in progress completes.
REQ-006 req0, req1  in  1 each  write request from requester 0 (CPU bus) and requester 1 (object/DMA side).
REQ-007 addr0, addr1  in  3 each  target register index per requester.
REQ-008 data0, data1  in  DW each  write data per requester.
REQ-009 ack0, ack1  out  1 each  one-cycle completion pulse to the granted requester.
REQ-010 err  out  1  one-cycle pulse, coincident with ack, when the granted address is >= NREG.
REQ-011 lat_d  out  DW  shared data bus to every slatchc d input.
REQ-012 lat_en  out  NREG  one-hot load enable to each slatchc en input.
REQ-013 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-014 FSM states: IDLE, SETUP, STROBE, DONE; encoding is free.
REQ-015 IDLE: if hold=0 and any req is high, register winner id, addr, data and go to SETUP; otherwise stay.
REQ-016 Arbitration is round-robin: on simultaneous req0/req1 the requester not served last wins; a lone requester always wins.
REQ-017 The last-served pointer updates only on entry to SETUP.
REQ-018 SETUP: lat_d drives latched data; lat_en all zero; unconditionally go to STROBE.
REQ-019 STROBE: lat_d unchanged; lat_en[addr]=1 for exactly this cycle if addr<NREG, else lat_en all zero; go to DONE.
REQ-020 DONE: ack of the granted requester is 1 for this cycle only; err=1 iff addr>=NREG; go to IDLE.
REQ-021 Latency: req sampled high in IDLE at edge N -> SETUP in cycle N+1, strobe in N+2, ack in N+3; next grant at earliest edge N+4.
REQ-022 Address and data are captured at grant; changes on addr/data/req after grant do not affect the transaction.
REQ-023 Deassertion of req after grant does not abort; ack is still issued.
REQ-024 A requester that holds req high after its ack is re-arbitrated as a new request at the following IDLE.
REQ-025 At most one bit of lat_en is high in any cycle; ack0 and ack1 are never high together.
REQ-026 lat_d holds its last value in IDLE (no glitch to zero between transactions).
REQ-027 hold rising while in SETUP/STROBE/DONE has no effect until return to IDLE.

Reset
REQ-028 resl=0 at a rising edge forces: state IDLE, lat_en=0, ack0=ack1=0, err=0, busy=0, lat_d=0, last-served pointer=requester 1 (requester 0 wins the first tie).
REQ-029 Reset asserted mid-transaction (any of SETUP/STROBE/DONE) aborts it: no lat_en pulse and no ack for that transaction, outputs as REQ-028 from the next cycle.
REQ-030 First grant after reset release needs resl=1 at the sampling edge; requests seen while resl=0 are ignored.

Verification
REQ-031 Single write: req0=1, addr0=2, data0=0x1234 at edge N -> lat_d=0x1234 at N+1, lat_en=6'b000100 at N+2 only, ack0 at N+3 only, busy high N+1..N+3.
REQ-032 Tie and fairness: req0,req1 held high from reset release with distinct addr/data -> grants alternate 0,1,0,1; each ack every 4 cycles; first ack is ack0.
REQ-033 Out of range: req1=1, addr1=7 (NREG=6) -> no lat_en bit ever set, ack1 and err pulse together at N+3.
REQ-034 Hold: hold=1 with req0=1 -> busy stays 0, no ack; hold drops at edge M -> lat_en at M+2, ack0 at M+3; hold raised during STROBE -> ack still issued.
REQ-035 Mid-reset: resl=0 in the STROBE cycle -> lat_en=0 that cycle onward, no ack0, busy=0; after resl=1 a pending req0 completes with full 4-cycle sequence.
REQ-036 Capture: change data0 from 0x00FF to 0xFF00 and drop req0 one cycle after grant -> lat_d stays 0x00FF through STROBE, ack0 still pulses.

Source files
------------

// File: rtl/slatch_wr_arb.sv
// rtl/slatch_wr_arb.sv - two-requester round-robin write arbiter driving a bank of slatchc registers
// Each grant runs SETUP (data on bus), STROBE (one-hot load enable), DONE (ack/err) and returns to IDLE.
module slatch_wr_arb #(
   parameter int NREG = 6,
   parameter int DW   = 16
) (
   input  logic            sys_clk,
   input  logic            resl,
   input  logic            hold,
   input  logic            req0,
   input  logic            req1,
   input  logic [2:0]      addr0,
   input  logic [2:0]      addr1,
   input  logic [DW-1:0]   data0,
   input  logic [DW-1:0]   data1,
   output logic            ack0,
   output logic            ack1,
   output logic            err,
   output logic [DW-1:0]   lat_d,
   output logic [NREG-1:0] lat_en,
   output logic            busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_STROBE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;
   localparam logic [3:0] NREG_W    = 4'(NREG);

   logic [1:0]    state_q, state_d;
   logic          last_q, last_d;    // 1: requester 1 was served most recently
   logic          gnt_q, gnt_d;
   logic [2:0]    addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic          winner;
   logic          in_range;

   always_comb begin
      winner = req1;
      if (req0 && req1) begin
         winner = ~last_q;
      end
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (!hold && (req0 || req1)) begin
               state_d = ST_SETUP;
               last_d  = winner;
               gnt_d   = winner;
               addr_d  = winner ? addr1 : addr0;
               data_d  = winner ? data1 : data0;
            end
         end
         ST_SETUP:  state_d = ST_STROBE;
         ST_STROBE: state_d = ST_DONE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!resl) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Strobe and completion are also qualified by resl so an aborted write never loads a register.
   always_comb begin
      lat_en = '0;
      for (int i = 0; i < NREG; i++) begin
         lat_en[i] = resl && (state_q == ST_STROBE) && (addr_q == 3'(i));
      end
   end

   assign in_range = ({1'b0, addr_q} < NREG_W);
   assign ack0     = resl && (state_q == ST_DONE) && !gnt_q;
   assign ack1     = resl && (state_q == ST_DONE) &&  gnt_q;
   assign err      = resl && (state_q == ST_DONE) && !in_range;
   assign busy     = (state_q != ST_IDLE);
   assign lat_d    = data_q;

endmodule

// File: tb/tb_slatch_wr_arb.sv
// tb/tb_slatch_wr_arb.sv - scoreboard bench for slatch_wr_arb with directed write sequences
module tb_slatch_wr_arb;

   localparam int NREG = 6;
   localparam int DW   = 16;

   logic            clk   = 1'b0;
   logic            resl  = 1'b0;
   logic            hold  = 1'b0;
   logic            req0  = 1'b0;
   logic            req1  = 1'b0;
   logic [2:0]      addr0 = '0;
   logic [2:0]      addr1 = '0;
   logic [DW-1:0]   data0 = '0;
   logic [DW-1:0]   data1 = '0;
   logic            ack0, ack1, err, busy;
   logic [DW-1:0]   lat_d;
   logic [NREG-1:0] lat_en;

   typedef struct {
      logic            id;
      logic            er;
      logic [NREG-1:0] en;
      logic [DW-1:0]   d;
      int              ack_cyc;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;
   // cyc is the index of the current clock period; the period after edge k is k+1
   int cyc    = 1;
   int n;

   logic [NREG-1:0] st_en  = '0;
   logic [DW-1:0]   st_d   = '0;
   int              st_cyc = -1;

   slatch_wr_arb #(.NREG(NREG), .DW(DW)) dut (
      .sys_clk (clk),
      .resl    (resl),
      .hold    (hold),
      .req0    (req0),
      .req1    (req1),
      .addr0   (addr0),
      .addr1   (addr1),
      .data0   (data0),
      .data1   (data1),
      .ack0    (ack0),
      .ack1    (ack1),
      .err     (err),
      .lat_d   (lat_d),
      .lat_en  (lat_en),
      .busy    (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic tick(input int cnt = 1);
      repeat (cnt) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic id, input logic er, input logic [NREG-1:0] en,
                       input logic [DW-1:0] d, input int ac);
      sb.push_back(exp_t'{id, er, en, d, ac});
   endtask

   // Monitor: pops the scoreboard whenever an ack appears
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         chk("lat_en_onehot", 32'(lat_en & (lat_en - 1'b1)), 32'd0);
         chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
         if (lat_en != '0) begin
            if (sb.size() == 0) chk("unexpected_strobe", 32'(lat_en), 32'd0);
            st_en  = lat_en;
            st_d   = lat_d;
            st_cyc = cyc;
         end
         if (ack0 || ack1) begin
            if (sb.size() == 0) begin
               chk("unexpected_ack", 32'({ack1, ack0}), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("ack_id", 32'(ack1), 32'(e.id));
               chk("ack_cycle", cyc, e.ack_cyc);
               chk("err", 32'(err), 32'(e.er));
               chk("lat_d_at_ack", 32'(lat_d), 32'(e.d));
               chk("strobe_en", 32'(st_en), 32'(e.en));
               if (e.en != '0) begin
                  chk("strobe_cycle", st_cyc, e.ack_cyc - 1);
                  chk("strobe_data", 32'(st_d), 32'(e.d));
               end
            end
            st_en  = '0;
            st_cyc = -1;
         end else begin
            chk("err_without_ack", 32'(err), 32'd0);
         end
      end
   end

   initial begin
      // Requests during reset are ignored
      req0 = 1'b1; addr0 = 3'd2; data0 = 16'h1111;
      tick(3);
      chk("rst_lat_en", 32'(lat_en), 32'd0);
      chk("rst_ack", 32'({ack1, ack0}), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_lat_d", 32'(lat_d), 32'd0);
      req0 = 1'b0; resl = 1'b1;
      tick(2);
      chk("idle_busy", 32'(busy), 32'd0);

      // Single write
      n = cyc; req0 = 1'b1; addr0 = 3'd2; data0 = 16'h1234;
      push(1'b0, 1'b0, 6'b000100, 16'h1234, n + 3);
      tick; req0 = 1'b0;
      chk("single_lat_d_setup", 32'(lat_d), 32'h1234);
      chk("single_en_setup", 32'(lat_en), 32'd0);
      chk("single_busy_n1", 32'(busy), 32'd1);
      tick; chk("single_busy_n2", 32'(busy), 32'd1);
      tick; chk("single_busy_n3", 32'(busy), 32'd1);
      tick; chk("single_busy_n4", 32'(busy), 32'd0);

      // Out-of-range address
      n = cyc; req1 = 1'b1; addr1 = 3'd7; data1 = 16'hBEEF;
      push(1'b1, 1'b1, 6'b000000, 16'hBEEF, n + 3);
      tick; req1 = 1'b0;
      tick(3);

      // Tie from reset release: grants alternate 0,1,0,1
      resl = 1'b0;
      tick(2);
      chk("rst2_lat_d", 32'(lat_d), 32'd0);
      req0 = 1'b1; addr0 = 3'd1; data0 = 16'hA0A0;
      req1 = 1'b1; addr1 = 3'd4; data1 = 16'h0B0B;
      resl = 1'b1; n = cyc;
      push(1'b0, 1'b0, 6'b000010, 16'hA0A0, n + 3);
      push(1'b1, 1'b0, 6'b010000, 16'h0B0B, n + 7);
      push(1'b0, 1'b0, 6'b000010, 16'hA0A0, n + 11);
      push(1'b1, 1'b0, 6'b010000, 16'h0B0B, n + 15);
      tick(13);
      req0 = 1'b0; req1 = 1'b0;
      tick(3);

      // Lone requester 1 right after serving 1; addr == NREG is out of range
      n = cyc; req1 = 1'b1; addr1 = 3'd6; data1 = 16'h6666;
      push(1'b1, 1'b1, 6'b000000, 16'h6666, n + 3);
      tick; req1 = 1'b0;
      tick(3);

      // Hold blocks grants; raised again during STROBE it does not abort
      hold = 1'b1; req0 = 1'b1; addr0 = 3'd5; data0 = 16'h5555;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("hold_busy", 32'(busy), 32'd0);
      end
      n = cyc; hold = 1'b0;
      push(1'b0, 1'b0, 6'b100000, 16'h5555, n + 3);
      tick; req0 = 1'b0;
      tick; hold = 1'b1;
      tick(2);
      hold = 1'b0;

      // Reset during STROBE aborts; pending req0 completes after release
      n = cyc; req0 = 1'b1; addr0 = 3'd3; data0 = 16'h3333;
      tick(2);
      resl = 1'b0;
      #1;
      chk("midrst_en_strobe", 32'(lat_en), 32'd0);
      chk("midrst_ack_strobe", 32'(ack0), 32'd0);
      tick;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_en", 32'(lat_en), 32'd0);
      chk("midrst_lat_d", 32'(lat_d), 32'd0);
      tick;
      n = cyc; resl = 1'b1;
      push(1'b0, 1'b0, 6'b001000, 16'h3333, n + 3);
      tick; req0 = 1'b0;
      tick(3);

      // Capture at grant: later data/addr/req changes are ignored
      n = cyc; req0 = 1'b1; addr0 = 3'd0; data0 = 16'h00FF;
      push(1'b0, 1'b0, 6'b000001, 16'h00FF, n + 3);
      tick;
      data0 = 16'hFF00; addr0 = 3'd5; req0 = 1'b0;
      tick; chk("capture_lat_d_strobe", 32'(lat_d), 32'h00FF);
      tick; chk("capture_lat_d_done", 32'(lat_d), 32'h00FF);
      tick(3);
      chk("idle_lat_d_hold", 32'(lat_d), 32'h00FF);

      tick(2);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
